// File: rtl/fetch_queue.sv
// Purpose: buffers PCs from fetch, reads sync imem, queues {pc, instr} pairs for decode.
// Latency: accept to dec_valid is 2 clk edges; sustains one accept per cycle.
// Backpressure: pc_ready reserves a slot for every in-flight read (pop credited); flush drops all.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W = 16,
    parameter int INSTR_W = 32,
    parameter logic [INSTR_W-1:0] NOP = 32'h00000013
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PC_W-1:0]              pc_in,
    input  logic                         pc_valid,
    output logic                         pc_ready,
    input  logic                         flush,
    output logic                         imem_req,
    output logic [PC_W-1:0]              imem_addr,
    input  logic [INSTR_W-1:0]           imem_rdata,
    output logic                         dec_valid,
    input  logic                         dec_ready,
    output logic [PC_W-1:0]              dec_pc,
    output logic [INSTR_W-1:0]           dec_instr,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [CW-1:0]      count_nxt;
    logic [CW:0]        occ;
    logic               inflight;
    logic [PC_W-1:0]    inflight_pc;
    logic               accept, write, pop;
    logic [PC_W-1:0]    head_pc, dec_pc_nxt;
    logic [INSTR_W-1:0] head_instr, dec_instr_nxt;

    assign dec_valid = (count != '0);
    assign pop       = dec_valid && dec_ready;
    assign occ       = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign pc_ready  = !rst && !flush && (occ < (CW+1)'(DEPTH));
    assign accept    = pc_valid && pc_ready;
    assign imem_req  = accept;
    assign imem_addr = {pc_in[PC_W-1:2], 2'b00};
    assign write     = inflight && !flush;

    // The new head bypasses the array when the returning word lands exactly at it.
    always_comb begin
        rd_ptr_nxt    = rd_ptr + AW'(pop);
        count_nxt     = count + CW'(write) - CW'(pop);
        head_pc       = pc_mem[rd_ptr_nxt];
        head_instr    = instr_mem[rd_ptr_nxt];
        if (write && (wr_ptr == rd_ptr_nxt)) begin
            head_pc    = inflight_pc;
            head_instr = imem_rdata;
        end
        dec_pc_nxt    = dec_pc;
        dec_instr_nxt = NOP;
        if (count_nxt != '0) begin
            dec_pc_nxt    = head_pc;
            dec_instr_nxt = head_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (write && !rst) begin
            pc_mem[wr_ptr]    <= inflight_pc;
            instr_mem[wr_ptr] <= imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            dec_pc      <= '0;
            dec_instr   <= NOP;
        end else if (flush) begin
            // dec_pc keeps its last value; the in-flight response is dropped.
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            inflight    <= 1'b0;
            dec_instr   <= NOP;
        end else begin
            wr_ptr    <= wr_ptr + AW'(write);
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
            inflight  <= accept;
            if (accept) begin
                inflight_pc <= pc_in;
            end
            dec_pc    <= dec_pc_nxt;
            dec_instr <= dec_instr_nxt;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus a queue scoreboard of accepted {pc, instr} pairs.
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct packed {
        logic [15:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk, rst, pc_valid, pc_ready, flush, imem_req, dec_valid, dec_ready;
    logic [15:0] pc_in, imem_addr, dec_pc;
    logic [31:0] imem_rdata, dec_instr;
    logic [2:0]  count;

    logic [31:0] rom [256];
    ent_t        q [$];
    bit          infl_m;
    int          checks, errors, n_acc, n_pop;

    fetch_queue #(.DEPTH(DEPTH), .PC_W(16), .INSTR_W(32), .NOP(NOP)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
        .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc), .dec_instr(dec_instr),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: scoreboard at negedge, then edge, then the memory answers the sampled request.
    task automatic tick();
        ent_t        e;
        bit          exp_rdy, acc, pp, r_s;
        int          cnt_m;
        logic [15:0] a_s;
        @(negedge clk);
        r_s = imem_req;
        a_s = imem_addr;
        if (rst) begin
            checks++;
            if (pc_ready !== 1'b0 || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL rst_quiet: pc_ready=%b imem_req=%b, required 0/0", pc_ready, imem_req);
            end
            q.delete();
            infl_m = 1'b0;
        end else begin
            cnt_m = q.size() - int'(infl_m);
            checks++;
            if (count !== 3'(cnt_m)) begin
                errors++;
                $display("FAIL sb_count: got %0d, required %0d", count, cnt_m);
            end
            checks++;
            if (dec_valid !== (cnt_m != 0)) begin
                errors++;
                $display("FAIL sb_dec_valid: got %b, required %b", dec_valid, cnt_m != 0);
            end
            pp = (cnt_m != 0) && dec_ready;
            if (pp) begin
                e = q.pop_front();
                n_pop++;
                checks++;
                if (dec_pc !== e.pc || dec_instr !== e.instr) begin
                    errors++;
                    $display("FAIL sb_pop: got %h/%h, required %h/%h", dec_pc, dec_instr, e.pc, e.instr);
                end
            end else if (cnt_m == 0) begin
                checks++;
                if (dec_instr !== NOP) begin
                    errors++;
                    $display("FAIL sb_empty_nop: got %h, required %h", dec_instr, NOP);
                end
            end
            exp_rdy = !flush && ((cnt_m + int'(infl_m) - int'(pp)) < DEPTH);
            acc = pc_valid && exp_rdy;
            checks++;
            if (pc_ready !== exp_rdy || imem_req !== acc) begin
                errors++;
                $display("FAIL sb_ready: pc_ready=%b imem_req=%b, required %b/%b", pc_ready, imem_req, exp_rdy, acc);
            end
            if (acc) begin
                checks++;
                if (imem_addr !== {pc_in[15:2], 2'b00}) begin
                    errors++;
                    $display("FAIL sb_addr: got %h, required %h", imem_addr, {pc_in[15:2], 2'b00});
                end
            end
            if (flush) begin
                q.delete();
                infl_m = 1'b0;
            end else begin
                infl_m = acc;
                if (acc) begin
                    e.pc = pc_in;
                    e.instr = rom[pc_in[9:2]];
                    q.push_back(e);
                    n_acc++;
                end
            end
        end
        @(posedge clk);
        #1;
        imem_rdata = r_s ? rom[a_s[9:2]] : 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1; pc_valid = 1'b1; pc_in = 16'h0100; flush = 1'b0; dec_ready = 1'b0;
        imem_rdata = 32'h0;
        #1;
        checks++;
        if (pc_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_pc_ready: got %b, required 0", pc_ready);
        end
        tick();
        tick();
        checks++;
        if (count !== 3'd0 || dec_valid !== 1'b0 || dec_pc !== 16'h0 || dec_instr !== NOP) begin
            errors++;
            $display("FAIL reset_state: count=%0d dec_valid=%b dec_pc=%h dec_instr=%h, required 0/0/0000/%h",
                     count, dec_valid, dec_pc, dec_instr, NOP);
        end
        rst = 1'b0; pc_valid = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] exp_i;
        dec_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            pc_valid = (k < 3);
            pc_in = 16'(4 * k);
            #1;
            checks++;
            if (dec_valid !== (k >= 2 && k <= 4)) begin
                errors++;
                $display("FAIL stream_valid[%0d]: got %b, required %b", k, dec_valid, (k >= 2 && k <= 4));
            end
            if (k >= 2 && k <= 4) begin
                exp_i = 32'hAAAA0001 + 32'(k - 2);
                checks++;
                if (dec_pc !== 16'(4 * (k - 2)) || dec_instr !== exp_i) begin
                    errors++;
                    $display("FAIL stream_data[%0d]: got %h/%h, required %h/%h", k, dec_pc, dec_instr, 16'(4 * (k - 2)), exp_i);
                end
            end
            tick();
        end
        pc_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int          acc0, pop0;
        logic [15:0] p;
        acc0 = n_acc; pop0 = n_pop; p = 16'h0020;
        dec_ready = 1'b0; pc_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pc_in = p;
            #1;
            if (pc_ready) p = p + 16'd4;
            tick();
        end
        #1;
        checks++;
        if (n_acc - acc0 != 4 || count !== 3'd4 || pc_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full: accepts=%0d count=%0d pc_ready=%b, required 4/4/0", n_acc - acc0, count, pc_ready);
        end
        dec_ready = 1'b1; pc_in = p;
        #1;
        checks++;
        if (pc_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_pop_credit: pc_ready=%b, required 1", pc_ready);
        end
        tick();
        dec_ready = 1'b0; pc_valid = 1'b0;
        tick();
        dec_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (n_pop - pop0 != 5 || count !== 3'd0) begin
            errors++;
            $display("FAIL bp_drain: pops=%0d count=%0d, required 5/0", n_pop - pop0, count);
        end
        dec_ready = 1'b0;
    endtask

    task automatic test_flush();
        dec_ready = 1'b0; pc_valid = 1'b1; pc_in = 16'h0010;
        tick();
        pc_in = 16'h0040; flush = 1'b1;
        #1;
        checks++;
        if (pc_ready !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_block: pc_ready=%b imem_req=%b, required 0/0", pc_ready, imem_req);
        end
        tick();
        flush = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || dec_valid !== 1'b0 || dec_instr !== NOP) begin
            errors++;
            $display("FAIL flush_state: count=%0d dec_valid=%b dec_instr=%h, required 0/0/%h", count, dec_valid, dec_instr, NOP);
        end
        checks++;
        if (pc_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_redirect_ready: got %b, required 1", pc_ready);
        end
        tick();
        pc_valid = 1'b0;
        tick();
        #1;
        checks++;
        if (dec_valid !== 1'b1 || dec_pc !== 16'h0040 || dec_instr !== rom[16]) begin
            errors++;
            $display("FAIL flush_target: got %b/%h/%h, required 1/0040/%h", dec_valid, dec_pc, dec_instr, rom[16]);
        end
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] p;
        p = 16'h0100;
        pc_valid = 1'b1;
        for (int i = 0; i < 13; i++) begin
            pc_in = p;
            p = p + 16'd4;
            dec_ready = (i >= 3);
            #1;
            if (i >= 3) begin
                checks++;
                if (count !== 3'd2) begin
                    errors++;
                    $display("FAIL b2b_count[%0d]: got %0d, required 2", i, count);
                end
            end
            tick();
        end
        pc_valid = 1'b0; dec_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL b2b_drain: count=%0d, required 0", count);
        end
        dec_ready = 1'b0;
    endtask

    task automatic test_misaligned();
        pc_valid = 1'b1; pc_in = 16'h0006;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0004) begin
            errors++;
            $display("FAIL misalign_addr: req=%b addr=%h, required 1/0004", imem_req, imem_addr);
        end
        tick();
        pc_valid = 1'b0;
        tick();
        #1;
        checks++;
        if (dec_pc !== 16'h0006 || dec_instr !== 32'hAAAA0002) begin
            errors++;
            $display("FAIL misalign_dec: got %h/%h, required 0006/aaaa0002", dec_pc, dec_instr);
        end
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        dec_ready = 1'b0; pc_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc_in = 16'(16'h0200 + 4 * i);
            tick();
        end
        pc_valid = 1'b0;
        tick();
        tick();
        #1;
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("FAIL rstmid_fill: count=%0d, required 3", count);
        end
        rst = 1'b1; pc_valid = 1'b1; pc_in = 16'h0300;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_req: got %b, required 0", imem_req);
        end
        tick();
        #1;
        checks++;
        if (count !== 3'd0 || dec_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_state: count=%0d dec_valid=%b, required 0/0", count, dec_valid);
        end
        rst = 1'b0; pc_valid = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0; errors = 0; n_acc = 0; n_pop = 0; infl_m = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 32'h5A000000 | 32'(i);
        rom[0] = 32'hAAAA0001;
        rom[1] = 32'hAAAA0002;
        rom[2] = 32'hAAAA0003;
        rom[4] = 32'hDEADBEEF;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_misaligned();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
